// File: rtl/addsub4_serial_if.sv
// Operand/result handshake bundle for the bit-serial add/sub block.
// master = producer/consumer side, slave = the arithmetic block.
interface addsub4_serial_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;

    modport master (
        output in_valid,
        output a,
        output b,
        output sign,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  s
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sign,
        input  out_ready,
        output in_ready,
        output out_valid,
        output s
    );

endinterface

// File: rtl/addsub4_serial.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one result bit per clock,
// LSB first, with valid/ready handshakes on operands and result.
module addsub4_serial #(
    parameter int unsigned WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    addsub4_serial_if.slave  bus
);

    localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] bx_sh_q, bx_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   s_r_q, s_r_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic fa_sum;
    logic fa_cout;

    assign accept   = bus.in_valid && (state_q == StIdle);
    assign last_bit = (cnt_q == LastCnt);

    // Single shared full-adder cell
    assign fa_sum  = a_sh_q[0] ^ bx_sh_q[0] ^ carry_q;
    assign fa_cout = (a_sh_q[0] & bx_sh_q[0]) | (a_sh_q[0] & carry_q) | (bx_sh_q[0] & carry_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid) state_d = StRun;
            StRun:  if (last_bit)     state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode state only, so no comb path from in_valid/out_ready
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.s         = s_r_q;
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        bx_sh_d = bx_sh_q;
        carry_d = carry_q;
        s_r_d   = s_r_q;
        cnt_d   = cnt_q;

        if (accept) begin
            a_sh_d  = bus.a;
            bx_sh_d = bus.b ^ {WIDTH{bus.sign}};
            carry_d = bus.sign;
            s_r_d   = '0;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (cnt_q == CntW'(i)) begin
                    s_r_d[i] = fa_sum;
                end
            end
            if (last_bit) begin
                s_r_d[WIDTH] = fa_cout;
            end
            carry_d = fa_cout;
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            bx_sh_d = {1'b0, bx_sh_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            bx_sh_q <= '0;
            carry_q <= 1'b0;
            s_r_q   <= '0;
            cnt_q   <= '0;
        end else begin
            a_sh_q  <= a_sh_d;
            bx_sh_q <= bx_sh_d;
            carry_q <= carry_d;
            s_r_q   <= s_r_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
